// File: rtl/uart_ctrl_pkg.sv
// Shared constants for masters of the UART control port: FSM encoding,
// default register addresses, status bit positions and a write-word helper.
package uart_ctrl_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 2'd0;
    localparam arb_state_t ST_RD_STAT  = 2'd1;
    localparam arb_state_t ST_CHK_STAT = 2'd2;
    localparam arb_state_t ST_WRITE    = 2'd3;

    localparam logic [2:0] UART_TX_ADDR   = 3'd0;
    localparam logic [2:0] UART_STAT_ADDR = 3'd2;

    localparam int UART_TXFULL_BIT = 1;

    function automatic logic [31:0] tx_word(input logic [7:0] tx_byte);
        return {24'b0, tx_byte};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// UART control port: the arbiter is the master, the UART register block the slave.
interface uart_tx_arbiter_if;

    // Strobe protocol: ctrl_wr_o / ctrl_rd_o are single-cycle strobes, never high together;
    // addr/data are meaningful only while a strobe is high (held 0 otherwise) and read data
    // on ctrl_data_i is valid the cycle after ctrl_rd_o. There is no back-pressure.
    logic        ctrl_wr_o;
    logic        ctrl_rd_o;
    logic [2:0]  ctrl_addr_o;
    logic [31:0] ctrl_data_o;
    logic [31:0] ctrl_data_i;

    modport master (
        output ctrl_wr_o,
        output ctrl_rd_o,
        output ctrl_addr_o,
        output ctrl_data_o,
        input  ctrl_data_i
    );

    modport slave (
        input  ctrl_wr_o,
        input  ctrl_rd_o,
        input  ctrl_addr_o,
        input  ctrl_data_o,
        output ctrl_data_i
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping from NUM_REQ-1 back to 0. The pointer itself lives in the caller.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);

    always_comb begin
        int k;
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (!valid_o && req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART control port among NUM_REQ byte senders: poll status
// until TX not full, then write the byte. Optional poll timeout: `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter logic [2:0] TX_ADDR    = UART_TX_ADDR,
    parameter logic [2:0] STAT_ADDR  = UART_STAT_ADDR,
    parameter int         TXFULL_BIT = UART_TXFULL_BIT,
    parameter int         POLL_LIMIT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*8-1:0] data_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic [NUM_REQ-1:0]   err_o,
    output logic                 busy_o,
    output arb_state_t           dbg_state_o,
    uart_tx_arbiter_if.master    ctrl
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t  state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_q, win_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] next_ptr;
    logic          tx_full;

    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;

    logic unused_rdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign tx_full      = ctrl.ctrl_data_i[TXFULL_BIT];
    assign unused_rdata = ^ctrl.ctrl_data_i;
    assign next_ptr     = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

`ifndef UART_ARB_TIMEOUT_EN
    localparam int unused_poll_limit = POLL_LIMIT;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        byte_d     = byte_q;
        poll_cnt_d = poll_cnt_q;
        ack_o      = '0;
        err_o      = '0;
        wr         = 1'b0;
        rd         = 1'b0;
        addr       = '0;
        wdata      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_d      = pick_idx;
                    byte_d     = data_i[{pick_idx, 3'b000} +: 8];
                    poll_cnt_d = '0;
                    state_d    = ST_RD_STAT;
                end
            end
            ST_RD_STAT: begin
                rd      = 1'b1;
                addr    = STAT_ADDR;
                state_d = ST_CHK_STAT;
            end
            ST_CHK_STAT: begin
                if (tx_full) begin
`ifdef UART_ARB_TIMEOUT_EN
                    // Give up on this byte once the poll budget is spent; it is acked as dropped.
                    if (({1'b0, poll_cnt_q} + 9'd1) >= 9'(POLL_LIMIT)) begin
                        ack_o[win_q] = 1'b1;
                        err_o[win_q] = 1'b1;
                        ptr_d        = next_ptr;
                        state_d      = ST_IDLE;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                        state_d    = ST_RD_STAT;
                    end
`else
                    state_d = ST_RD_STAT;
`endif
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr           = 1'b1;
                addr         = TX_ADDR;
                wdata        = tx_word(byte_q);
                ack_o[win_q] = 1'b1;
                ptr_d        = next_ptr;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            byte_q     <= '0;
            poll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            byte_q     <= byte_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign ctrl.ctrl_wr_o   = wr;
    assign ctrl.ctrl_rd_o   = rd;
    assign ctrl.ctrl_addr_o = addr;
    assign ctrl.ctrl_data_o = wdata;
    assign busy_o           = (state_q != ST_IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART status responder and a byte/ack scoreboard.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic        busy;
  arb_state_t  dbg_state;

  uart_tx_arbiter_if ctrl_if();

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .POLL_LIMIT (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .data_i      (data),
    .ack_o       (ack),
    .err_o       (err),
    .busy_o      (busy),
    .dbg_state_o (dbg_state),
    .ctrl        (ctrl_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART status responder: reports full for the next full_left polls, then not full.
  int full_left = 0;
  always @(posedge clk) begin
    if (ctrl_if.ctrl_rd_o) begin
      if (full_left > 0) begin
        ctrl_if.ctrl_data_i <= 32'hFFFF_FFFF;
        full_left = full_left - 1;
      end else begin
        ctrl_if.ctrl_data_i <= 32'hFFFF_FFFD;
      end
    end else begin
      ctrl_if.ctrl_data_i <= 32'h0000_0002;
    end
  end

  // scoreboard
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         exp_ack_q[$];
  logic [7:0] wr_log[$];
  int         ack_log[$];
  int         err_log[$];
  int         rd_cnt = 0;
  int         viol = 0;
  bit         hold_req = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    exp_ack_q.delete();
    wr_log.delete();
    ack_log.delete();
    err_log.delete();
    rd_cnt = 0;
  endtask

  task automatic observe();
    if (ctrl_if.ctrl_wr_o && ctrl_if.ctrl_rd_o) viol++;
    if (ctrl_if.ctrl_rd_o) begin
      rd_cnt++;
      if (ctrl_if.ctrl_addr_o != UART_STAT_ADDR || ctrl_if.ctrl_data_o != 32'h0) viol++;
    end
    if (ctrl_if.ctrl_wr_o) begin
      wr_log.push_back(ctrl_if.ctrl_data_o[7:0]);
      if (ctrl_if.ctrl_addr_o != UART_TX_ADDR || ctrl_if.ctrl_data_o[31:8] != 24'h0) viol++;
      if (ack == 4'h0 || err != 4'h0) viol++;
    end
    if (!ctrl_if.ctrl_wr_o && !ctrl_if.ctrl_rd_o &&
        (ctrl_if.ctrl_addr_o != 3'h0 || ctrl_if.ctrl_data_o != 32'h0)) viol++;
    if (ack != 4'h0) begin
      if ($countones(ack) != 1) viol++;
      if ((err & ~ack) != 4'h0) viol++;
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          ack_log.push_back(i);
          err_log.push_back(int'(err[i]));
          if (!hold_req) req[i] = 1'b0;
        end
      end
    end else if (err != 4'h0) begin
      viol++;
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run(input string tag, input int n_acks);
    int cycles;
    cycles = 0;
    while (ack_log.size() < n_acks && cycles < 300) begin
      step();
      cycles++;
    end
    check_eq({tag, "_acks_seen"}, ack_log.size(), n_acks);
    if (hold_req) req = '0;
    step();
  endtask

  task automatic check_sb(input string tag);
    check_eq({tag, "_n_wr"}, wr_log.size(), exp_q.size());
    check_eq({tag, "_n_ack"}, ack_log.size(), exp_ack_q.size());
    foreach (exp_q[i])
      if (i < wr_log.size()) check_eq($sformatf("%s_byte%0d", tag, i), wr_log[i], exp_q[i]);
    foreach (exp_ack_q[i])
      if (i < ack_log.size()) check_eq($sformatf("%s_ack%0d", tag, i), ack_log[i], exp_ack_q[i]);
  endtask

  initial begin
    // reset state
    do_reset();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_wr", ctrl_if.ctrl_wr_o, 1'b0);
    check_eq("rst_rd", ctrl_if.ctrl_rd_o, 1'b0);
    check_eq("rst_addr", ctrl_if.ctrl_addr_o, 3'h0);
    check_eq("rst_data", ctrl_if.ctrl_data_o, 32'h0);
    check_eq("rst_ack", ack, 4'h0);
    check_eq("rst_err", err, 4'h0);

    // 1: single byte, exact cycle sequence
    clear_logs();
    data[7:0] = 8'hA5;
    req = 4'b0001;
    step();
    check_eq("t1_rd", ctrl_if.ctrl_rd_o, 1'b1);
    check_eq("t1_rd_addr", ctrl_if.ctrl_addr_o, 3'd2);
    check_eq("t1_busy", busy, 1'b1);
    step();
    check_eq("t1_chk_strobes", {ctrl_if.ctrl_wr_o, ctrl_if.ctrl_rd_o, ack}, 6'h0);
    step();
    check_eq("t1_wr", ctrl_if.ctrl_wr_o, 1'b1);
    check_eq("t1_wr_addr", ctrl_if.ctrl_addr_o, 3'd0);
    check_eq("t1_wr_data", ctrl_if.ctrl_data_o, 32'h0000_00A5);
    check_eq("t1_ack", ack, 4'b0001);
    step();
    check_eq("t1_ack_gone", ack, 4'h0);
    check_eq("t1_idle", busy, 1'b0);

    // 2: all requesters held high, rotation 0,1,2,3,0
    do_reset();
    clear_logs();
    data = 32'h4433_2211;
    hold_req = 1'b1;
    req = 4'b1111;
    run("t2", 5);
    hold_req = 1'b0;
    exp_ack_q = '{0, 1, 2, 3, 0};
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    check_sb("t2");

    // pointer at 1 after t2: requesters 3 and 1 pending -> 1 then 3
    clear_logs();
    req = 4'b1010;
    run("tp", 2);
    exp_ack_q = '{1, 3};
    exp_q = '{8'h22, 8'h44};
    check_sb("tp");

    // 3: five full polls then not full -> 6 reads, 1 write
    clear_logs();
    data[23:16] = 8'h7E;
    full_left = 5;
    req = 4'b0100;
    run("t3", 1);
    check_eq("t3_rd_cnt", rd_cnt, 6);
    exp_ack_q = '{2};
    exp_q = '{8'h7E};
    check_sb("t3");

    // 6: winner changes its byte after grant
    clear_logs();
    data[7:0] = 8'h5A;
    req = 4'b0001;
    step();
    data[7:0] = 8'hFF;
    run("t6", 1);
    exp_ack_q = '{0};
    exp_q = '{8'h5A};
    check_sb("t6");

`ifdef UART_ARB_TIMEOUT_EN
    // 4: status stuck full -> dropped after 4 polls with err, then next request served
    clear_logs();
    full_left = 1000;
    req = 4'b0010;
    run("t4", 1);
    full_left = 0;
    check_eq("t4_rd_cnt", rd_cnt, 4);
    check_eq("t4_n_wr", wr_log.size(), 0);
    check_eq("t4_err", err_log.size() > 0 ? err_log[0] : -1, 1);
    check_eq("t4_ack_idx", ack_log.size() > 0 ? ack_log[0] : -1, 1);
    clear_logs();
    data[7:0] = 8'hC3;
    req = 4'b0001;
    run("t4b", 1);
    check_eq("t4b_err", err_log.size() > 0 ? err_log[0] : -1, 0);
    exp_ack_q = '{0};
    exp_q = '{8'hC3};
    check_sb("t4b");
`endif

    // 5: reset during CHK_STAT aborts; held requests re-served from pointer 0
    clear_logs();
    req = 4'b0010;
    run("t5a", 1);
    req = 4'b1001;
    step();
    step();
    check_eq("t5_in_chk", dbg_state, ST_CHK_STAT);
    rst = 1'b1;
    step();
    check_eq("t5_rst_outs", {busy, ctrl_if.ctrl_wr_o, ctrl_if.ctrl_rd_o, ack, err}, 11'h0);
    check_eq("t5_rst_addr_data", {ctrl_if.ctrl_addr_o, ctrl_if.ctrl_data_o}, 35'h0);
    check_eq("t5_no_abort_ack", ack_log.size(), 1);
    rst = 1'b0;
    clear_logs();
    run("t5", 2);
    exp_ack_q = '{0, 3};
    exp_q = '{data[7:0], data[31:24]};
    check_sb("t5");

    check_eq("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
